// File: rtl/rv_encode_pkg.sv
// Shared RV32I encoding constants: command classes, opcodes, funct fields and
// the ALU control codes also used by the single-cycle decoder.
package rv_encode_pkg;

  typedef enum logic [2:0] {
    CLS_LW  = 3'b000,
    CLS_SW  = 3'b001,
    CLS_R   = 3'b010,
    CLS_I   = 3'b011,
    CLS_BEQ = 3'b100,
    CLS_JAL = 3'b101
  } cls_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  function automatic logic alu_legal(input logic [2:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: alu_legal = 1'b1;
      default:                                    alu_legal = 1'b0;
    endcase
  endfunction

  // add and sub share funct3; funct7 tells them apart on R-type.
  function automatic logic [2:0] alu_funct3(input logic [2:0] alu);
    case (alu)
      ALU_SLT: alu_funct3 = F3_SLT;
      ALU_OR:  alu_funct3 = F3_OR;
      ALU_AND: alu_funct3 = F3_AND;
      default: alu_funct3 = F3_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH x W FIFO with occupancy count; head word reads as zero when empty.
// Push ignored when full, pop ignored when empty; no bypass through a full FIFO.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// Packs field-level commands into RV32I words, buffered and emitted with a running byte address;
// one-cycle latency through an empty FIFO, in_ready low while full. RV_ENC_RANGE_CHECK_EN adds err_range.
module rv_instr_encoder
  import rv_encode_pkg::*;
#(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_class,
  input  logic [2:0]              in_alu,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [31:0]             in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [$clog2(DEPTH):0]  count,
`ifdef RV_ENC_RANGE_CHECK_EN
  output logic                    err_range,
`endif
  output logic                    err_illegal,
  input  logic                    clr_err
);

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal;
  logic        range_bad;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  assign f3 = alu_funct3(in_alu);
  assign f7 = (in_alu == ALU_SUB) ? F7_SUB : F7_ZERO;

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (in_class)
      CLS_LW:  instr = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OP_LOAD};
      CLS_SW:  instr = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OP_STORE};
      CLS_R: begin
        instr   = {f7, in_rs2, in_rs1, f3, in_rd, OP_R};
        illegal = ~alu_legal(in_alu);
      end
      CLS_I: begin
        // There is no subi; an immediate subtract must come in as add of -imm.
        instr   = {in_imm[11:0], in_rs1, f3, in_rd, OP_I};
        illegal = ~alu_legal(in_alu) | (in_alu == ALU_SUB);
      end
      CLS_BEQ: instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                        in_imm[4:1], in_imm[11], OP_BRANCH};
      CLS_JAL: instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, OP_JAL};
      default: illegal = 1'b1;
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = in_imm;

  always_comb begin
    range_bad = 1'b0;
    case (in_class)
      CLS_LW, CLS_SW, CLS_I:
        range_bad = (simm > 32'sd2047) || (simm < -32'sd2048);
      CLS_BEQ:
        range_bad = (simm > 32'sd4094) || (simm < -32'sd4096) || in_imm[0];
      CLS_JAL:
        range_bad = (simm > 32'sd1048574) || (simm < -32'sd1048576) || in_imm[0];
      default: range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              err_range <= 1'b0;
    else if (accept & range_bad & ~illegal) err_range <= 1'b1;
    else if (clr_err)                       err_range <= 1'b0;
  end
`else
  logic unused_imm_hi;
  assign range_bad     = 1'b0;
  assign unused_imm_hi = ^in_imm[31:21];
`endif

  assign in_ready  = ~full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~illegal & ~range_bad;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (instr),
    .pop       (pop),
    .pop_data  (out_instr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  err_illegal <= 1'b0;
    else if (accept & illegal)  err_illegal <= 1'b1;
    else if (clr_err)           err_illegal <= 1'b0;
  end

  // out_addr tracks the head entry, so only pops move it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    out_addr <= BASE_ADDR;
    else if (pop) out_addr <= out_addr + ADDR_W'(4);
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Table-driven bench for rv_instr_encoder with a queue scoreboard on the output stream.
module tb_rv_instr_encoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_alu;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [2:0]  count;
  logic        err_illegal;
  logic        clr_err;
`ifdef RV_ENC_RANGE_CHECK_EN
  logic        err_range;
`endif

  rv_instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_alu      (in_alu),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .count       (count),
`ifdef RV_ENC_RANGE_CHECK_EN
    .err_range   (err_range),
`endif
    .err_illegal (err_illegal),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  cls;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          drop;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  vec_t        vecs[15];

  function automatic vec_t mk(input string name, input logic [2:0] cls, input logic [2:0] alu,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input bit drop, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.cls = cls; v.alu = alu; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.drop = drop; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input vec_t v);
    int budget;
    budget   = 0;
    in_class = v.cls; in_alu = v.alu; in_rd = v.rd;
    in_rs1   = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
    in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      tick(1);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready stuck at 0 expected 1", v.name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!v.drop) exp_q.push_back(v.exp);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 100) begin
      tick(1);
      b++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    exp_addr = BASE;
    tick(1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_instr", out_instr, 32'd0);
    reset = 1'b0;
    tick(1);
  endtask

  // Each word is checked the half cycle before the edge that consumes it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h at %h expected no word", out_instr, out_addr);
      end else begin
        chk("word_instr", out_instr, exp_q.pop_front());
        chk("word_addr", out_addr, exp_addr);
        exp_addr += 32'd4;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t bad;
    logic [31:0] hold_i;

    vecs[0]  = mk("add",   3'b010, 3'b000, 5'd3,  5'd1,  5'd2,  32'd0,        0, 32'h002081B3);
    vecs[1]  = mk("sub",   3'b010, 3'b001, 5'd5,  5'd6,  5'd7,  32'd0,        0, 32'h407302B3);
    vecs[2]  = mk("lw",    3'b000, 3'b000, 5'd4,  5'd2,  5'd0,  -32'sd4,      0, 32'hFFC12203);
    vecs[3]  = mk("sw",    3'b001, 3'b000, 5'd0,  5'd2,  5'd5,  32'd8,        0, 32'h00512423);
    vecs[4]  = mk("beq",   3'b100, 3'b000, 5'd0,  5'd1,  5'd2,  -32'sd8,      0, 32'hFE208CE3);
    vecs[5]  = mk("jal",   3'b101, 3'b000, 5'd1,  5'd0,  5'd0,  32'd16,       0, 32'h010000EF);
    vecs[6]  = mk("addi",  3'b011, 3'b000, 5'd10, 5'd11, 5'd31, -32'sd1,      0, 32'hFFF58513);
    vecs[7]  = mk("or",    3'b010, 3'b011, 5'd1,  5'd2,  5'd3,  32'd0,        0, 32'h003160B3);
    vecs[8]  = mk("and",   3'b010, 3'b010, 5'd31, 5'd30, 5'd29, 32'd0,        0, 32'h01DF7FB3);
    vecs[9]  = mk("slti",  3'b011, 3'b101, 5'd2,  5'd3,  5'd0,  32'd2047,     0, 32'h7FF1A113);
    vecs[10] = mk("sw_lo", 3'b001, 3'b000, 5'd9,  5'd8,  5'd7,  -32'sd2048,   0, 32'h80742023);
    vecs[11] = mk("jal_m", 3'b101, 3'b000, 5'd5,  5'd3,  5'd4,  -32'sd2,      0, 32'hFFFFF2EF);
    vecs[12] = mk("beq_h", 3'b100, 3'b000, 5'd6,  5'd3,  5'd4,  32'd4094,     0, 32'h7E418FE3);
    vecs[13] = mk("andi",  3'b011, 3'b010, 5'd1,  5'd1,  5'd0,  32'h000000F0, 0, 32'h0F00F093);
    vecs[14] = mk("slt",   3'b010, 3'b101, 5'd8,  5'd9,  5'd10, 32'd0,        0, 32'h00A4A433);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    in_class = '0; in_alu = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = BASE;
    tick(2);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_addr", out_addr, BASE);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_err_illegal", 32'(err_illegal), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // One-cycle latency through an empty FIFO.
    out_ready = 1'b1;
    send(vecs[0]);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < 15; i++) send(vecs[i]);
    drain();

    // Fill to DEPTH with the consumer stalled, then release.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[6 + i]);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_instr, vecs[6].exp);
    hold_i = out_instr;
    fork
      send(vecs[10]);
      begin
        tick(3);
        chk("hold_instr", out_instr, hold_i);
        chk("hold_addr", out_addr, BASE);
        chk("stall_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        #0;
        chk("no_bypass_in_ready", 32'(in_ready), 32'd0);
      end
    join
    drain();

    // Illegal commands complete the handshake but never reach the FIFO.
    send(mk("cls110", 3'b110, 3'b000, 5'd1, 5'd1, 5'd1, 32'd0, 1, 32'd0));
    send(mk("isub",   3'b011, 3'b001, 5'd1, 5'd1, 5'd0, 32'd4, 1, 32'd0));
    send(mk("ralu4",  3'b010, 3'b100, 5'd1, 5'd1, 5'd1, 32'd0, 1, 32'd0));
    chk("illegal_flag", 32'(err_illegal), 32'd1);
    chk("illegal_count", 32'(count), 32'd0);
    chk("illegal_out_valid", 32'(out_valid), 32'd0);
    chk("illegal_out_addr", out_addr, exp_addr);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err", 32'(err_illegal), 32'd0);
    bad = mk("cls111", 3'b111, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'd0);
    clr_err = 1'b1;
    send(bad);
    clr_err = 1'b0;
    chk("set_beats_clr", 32'(err_illegal), 32'd1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_again", 32'(err_illegal), 32'd0);
    send(vecs[1]);
    drain();

    // Reset with words still buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[2 + i]);
    chk("midstream_count", 32'(count), 32'd3);
    do_reset();
    out_ready = 1'b1;
    send(vecs[0]);
    drain();

`ifdef RV_ENC_RANGE_CHECK_EN
    chk("range_flag_init", 32'(err_range), 32'd0);
    send(mk("lw_2048", 3'b000, 3'b000, 5'd1, 5'd2, 5'd0, 32'd2048, 1, 32'd0));
    chk("range_flag_set", 32'(err_range), 32'd1);
    chk("range_count", 32'(count), 32'd0);
    chk("range_not_illegal", 32'(err_illegal), 32'd0);
    send(mk("beq_6", 3'b100, 3'b000, 5'd0, 5'd0, 5'd0, 32'd6, 0, 32'h00000363));
    send(mk("beq_7", 3'b100, 3'b000, 5'd0, 5'd0, 5'd0, 32'd7, 1, 32'd0));
    drain();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("range_clr", 32'(err_range), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
